// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - M-cycle sequencer: IR, step counter, bus handshake, commit strobe
module cpu_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       done,
  input  logic       is_cond,
  input  logic [2:0] next_cond,
  input  logic       cc_met,
  input  logic       mem_access,
  input  logic       write_mem,
  input  logic       mem_ready,
  input  logic [7:0] mem_rdata,
  output logic [7:0] opcode,
  output logic [2:0] step,
  output logic       mem_req,
  output logic       mem_we,
  output logic       fetch,
  output logic       commit,
  output logic       illegal,
  output logic       bus_error
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    EXEC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Last wait count that may still be followed by a successful mem_ready.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wcnt;
  logic       stalled;
  logic       timeout_hit;

  // Bus request, write qualifier, fetch marker and commit strobe; all forced low during reset.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    fetch   = 1'b0;
    commit  = 1'b0;
    if (!reset) begin
      case (state)
        BOOT: begin
          mem_req = 1'b1;
          fetch   = 1'b1;
          commit  = mem_ready;
        end
        EXEC: begin
          mem_req = mem_access;
          mem_we  = write_mem & mem_access;
          fetch   = done;
          commit  = mem_access ? mem_ready : 1'b1;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

  // A stalled request whose wait count is about to reach TIMEOUT is a bus error.
  always_comb begin
    stalled     = mem_req & ~mem_ready;
    timeout_hit = stalled & (wcnt == WAIT_LAST);
  end

  // Sequencer state, IR, step counter, wait counter and sticky fault flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BOOT;
      opcode    <= 8'h00;
      step      <= 3'd0;
      wcnt      <= 8'd0;
      illegal   <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      if (commit) begin
        wcnt <= 8'd0;
      end else if (stalled) begin
        wcnt <= wcnt + 8'd1;
      end

      case (state)
        BOOT: begin
          if (commit) begin
            opcode <= mem_rdata;
            step   <= 3'd0;
            state  <= EXEC;
          end else if (timeout_hit) begin
            state     <= LOCKED;
            bus_error <= 1'b1;
          end
        end
        EXEC: begin
          if (commit) begin
            if (done) begin
              opcode <= mem_rdata;
              step   <= 3'd0;
            end else if (is_cond && !cc_met) begin
              step <= next_cond;
            end else if (step == 3'd7) begin
              state   <= LOCKED;
              illegal <= 1'b1;
            end else begin
              step <= step + 3'd1;
            end
          end else if (timeout_hit) begin
            state     <= LOCKED;
            bus_error <= 1'b1;
          end
        end
        default: begin
          state <= LOCKED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       done, is_cond, cc_met, mem_access, write_mem, mem_ready;
  logic [2:0] next_cond;
  logic [7:0] mem_rdata;
  logic [7:0] opcode;
  logic [2:0] step;
  logic       mem_req, mem_we, fetch, commit, illegal, bus_error;

  int vectors = 0;
  int miscompares = 0;

  cpu_sequencer #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .done(done), .is_cond(is_cond), .next_cond(next_cond),
    .cc_met(cc_met), .mem_access(mem_access), .write_mem(write_mem), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .opcode(opcode), .step(step), .mem_req(mem_req), .mem_we(mem_we),
    .fetch(fetch), .commit(commit), .illegal(illegal), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    done = 1'b0; is_cond = 1'b0; next_cond = 3'd0; cc_met = 1'b0;
    mem_access = 1'b0; write_mem = 1'b0; mem_ready = 1'b0; mem_rdata = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    mem_ready = 1'b1;
    tick(); tick();
    vectors++; if (opcode !== 8'h00) begin miscompares++; $display("FAIL rst_opcode: got %h want 00", opcode); end
    vectors++; if (step !== 3'd0) begin miscompares++; $display("FAIL rst_step: got %0d want 0", step); end
    vectors++; if ({mem_req, mem_we, fetch, commit} !== 4'b0000) begin miscompares++; $display("FAIL rst_outputs: got %b want 0000", {mem_req, mem_we, fetch, commit}); end
    vectors++; if ({illegal, bus_error} !== 2'b00) begin miscompares++; $display("FAIL rst_flags: got %b want 00", {illegal, bus_error}); end
  endtask

  task automatic test_boot();
    mem_ready = 1'b1; mem_rdata = 8'h3E; write_mem = 1'b1;
    reset = 1'b0;
    #1;
    vectors++; if ({fetch, mem_req, mem_we, commit} !== 4'b1101) begin miscompares++; $display("FAIL boot_fetch: got %b want 1101", {fetch, mem_req, mem_we, commit}); end
    tick();
    write_mem = 1'b0;
    vectors++; if ({opcode, step} !== {8'h3E, 3'd0}) begin miscompares++; $display("FAIL boot_ir: got %h/%0d want 3e/0", opcode, step); end
    // LD A,n: step 0 reads the immediate, step 1 is done and fetches next opcode
    mem_access = 1'b1; mem_rdata = 8'h42; mem_ready = 1'b1; done = 1'b0;
    #1;
    vectors++; if ({fetch, mem_req, commit} !== 3'b011) begin miscompares++; $display("FAIL ldan_s0: got %b want 011", {fetch, mem_req, commit}); end
    tick();
    vectors++; if ({opcode, step} !== {8'h3E, 3'd1}) begin miscompares++; $display("FAIL ldan_s1: got %h/%0d want 3e/1", opcode, step); end
    done = 1'b1; mem_rdata = 8'h00;
    #1;
    vectors++; if ({fetch, mem_req, commit} !== 3'b111) begin miscompares++; $display("FAIL ldan_done: got %b want 111", {fetch, mem_req, commit}); end
    tick();
    vectors++; if ({opcode, step} !== {8'h00, 3'd0}) begin miscompares++; $display("FAIL ldan_next: got %h/%0d want 00/0", opcode, step); end
  endtask

  task automatic test_wait_states();
    int nreq = 0;
    int ncom = 0;
    idle_inputs();
    // two internal steps to reach step 2
    tick(); tick();
    vectors++; if (step !== 3'd2) begin miscompares++; $display("FAIL ws_reach: got %0d want 2", step); end
    mem_access = 1'b1; write_mem = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      if (mem_req === 1'b1) nreq++;
      if (commit === 1'b1) ncom++;
      if (i < 3) begin
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL ws_we: got %b want 1", mem_we); end
      end
      tick();
      if (i < 3) begin
        vectors++; if (step !== 3'd2) begin miscompares++; $display("FAIL ws_hold: got %0d want 2", step); end
      end
    end
    vectors++; if (nreq !== 4) begin miscompares++; $display("FAIL ws_req_clocks: got %0d want 4", nreq); end
    vectors++; if (ncom !== 1) begin miscompares++; $display("FAIL ws_commits: got %0d want 1", ncom); end
    vectors++; if (step !== 3'd3) begin miscompares++; $display("FAIL ws_advance: got %0d want 3", step); end
    mem_access = 1'b0; write_mem = 1'b1;
    #1;
    vectors++; if ({mem_req, mem_we} !== 2'b00) begin miscompares++; $display("FAIL ws_we_gate: got %b want 00", {mem_req, mem_we}); end
    write_mem = 1'b0; done = 1'b1; mem_access = 1'b1; mem_ready = 1'b1; mem_rdata = 8'h00;
    tick();
    idle_inputs();
  endtask

  task automatic test_conditional();
    tick();
    is_cond = 1'b1; next_cond = 3'd5; cc_met = 1'b0;
    tick();
    vectors++; if (step !== 3'd5) begin miscompares++; $display("FAIL cond_not_met: got %0d want 5", step); end
    idle_inputs(); done = 1'b1; mem_access = 1'b1; mem_ready = 1'b1;
    tick();
    idle_inputs();
    tick();
    is_cond = 1'b1; next_cond = 3'd5; cc_met = 1'b1;
    tick();
    vectors++; if (step !== 3'd2) begin miscompares++; $display("FAIL cond_met: got %0d want 2", step); end
    done = 1'b1; cc_met = 1'b0; mem_access = 1'b1; mem_ready = 1'b1; mem_rdata = 8'h77;
    tick();
    vectors++; if ({opcode, step} !== {8'h77, 3'd0}) begin miscompares++; $display("FAIL cond_done_wins: got %h/%0d want 77/0", opcode, step); end
    idle_inputs();
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 7; i++) tick();
    vectors++; if ({step, illegal} !== {3'd7, 1'b0}) begin miscompares++; $display("FAIL ill_step7: got %0d/%b want 7/0", step, illegal); end
    tick();
    vectors++; if ({step, illegal, opcode} !== {3'd7, 1'b1, 8'h77}) begin miscompares++; $display("FAIL ill_lock: got %0d/%b/%h want 7/1/77", step, illegal, opcode); end
    done = 1'b1; mem_access = 1'b1; mem_ready = 1'b1; mem_rdata = 8'h11;
    #1;
    vectors++; if ({mem_req, commit, fetch} !== 3'b000) begin miscompares++; $display("FAIL ill_quiet: got %b want 000", {mem_req, commit, fetch}); end
    tick(); tick();
    vectors++; if ({opcode, step, illegal} !== {8'h77, 3'd7, 1'b1}) begin miscompares++; $display("FAIL ill_hold: got %h/%0d/%b want 77/7/1", opcode, step, illegal); end
  endtask

  task automatic test_timeout();
    int early = 0;
    reset = 1'b1; idle_inputs(); tick(); reset = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      #1;
      if (commit !== 1'b0 || mem_req !== 1'b1 || bus_error !== 1'b0) early++;
      tick();
    end
    vectors++; if (early !== 0) begin miscompares++; $display("FAIL to_waiting: got %0d bad clocks want 0", early); end
    vectors++; if ({bus_error, mem_req} !== 2'b10) begin miscompares++; $display("FAIL to_error: got %b want 10", {bus_error, mem_req}); end
    mem_ready = 1'b1; mem_rdata = 8'h5A;
    #1;
    vectors++; if (commit !== 1'b0) begin miscompares++; $display("FAIL to_late_ready: got %b want 0", commit); end
    tick();
    vectors++; if (opcode !== 8'h00) begin miscompares++; $display("FAIL to_opcode_hold: got %h want 00", opcode); end
    reset = 1'b1; idle_inputs(); tick(); reset = 1'b0;
    for (int i = 1; i <= 14; i++) tick();
    mem_ready = 1'b1; mem_rdata = 8'hA5;
    #1;
    vectors++; if (commit !== 1'b1) begin miscompares++; $display("FAIL to_clock15_commit: got %b want 1", commit); end
    tick();
    vectors++; if ({bus_error, opcode, step} !== {1'b0, 8'hA5, 3'd0}) begin miscompares++; $display("FAIL to_clock15_ok: got %b/%h/%0d want 0/a5/0", bus_error, opcode, step); end
  endtask

  task automatic test_reset_mid_wait();
    idle_inputs(); mem_access = 1'b1; write_mem = 1'b1;
    #1;
    vectors++; if ({mem_req, mem_we} !== 2'b11) begin miscompares++; $display("FAIL rmw_req: got %b want 11", {mem_req, mem_we}); end
    tick();
    #2;
    reset = 1'b1;
    #1;
    vectors++; if ({mem_req, mem_we, fetch, commit} !== 4'b0000) begin miscompares++; $display("FAIL rmw_outputs: got %b want 0000", {mem_req, mem_we, fetch, commit}); end
    vectors++; if ({opcode, step} !== {8'h00, 3'd0}) begin miscompares++; $display("FAIL rmw_regs: got %h/%0d want 00/0", opcode, step); end
    tick();
    idle_inputs(); mem_ready = 1'b1; mem_rdata = 8'h3E;
    reset = 1'b0;
    #1;
    vectors++; if ({fetch, mem_req, commit} !== 3'b111) begin miscompares++; $display("FAIL rmw_boot: got %b want 111", {fetch, mem_req, commit}); end
    tick();
    vectors++; if (opcode !== 8'h3E) begin miscompares++; $display("FAIL rmw_boot_ir: got %h want 3e", opcode); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_wait_states();
    test_conditional();
    test_illegal();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
